// File: rtl/int_queue_pkg.sv
// Shared constants and helpers for the priority-sorted interrupt queue.
package int_queue_pkg;

    localparam int unsigned DEF_WID      = 28;
    localparam int unsigned DEF_PRI_BITS = 4;
    localparam int unsigned DEF_NLEV     = 1 << DEF_PRI_BITS;

    // Priority field sits in the top bits of the request word.
    function automatic logic [DEF_PRI_BITS-1:0] pri_of(input logic [DEF_WID-1:0] w);
        return w[DEF_WID-1 -: DEF_PRI_BITS];
    endfunction

    // Ceiling log2, usable in constant expressions.
    function automatic int unsigned log2(input int unsigned n);
        int unsigned r;
        r = 0;
        while ((32'd1 << r) < n) r++;
        return r;
    endfunction

    // Index of the highest set bit; zero when no bit is set.
    function automatic logic [DEF_PRI_BITS-1:0] hi_bit(input logic [DEF_NLEV-1:0] v);
        logic [DEF_PRI_BITS-1:0] r;
        r = '0;
        for (int unsigned k = 0; k < DEF_NLEV; k++) begin
            if (v[k]) r = DEF_PRI_BITS'(k);
        end
        return r;
    endfunction

endpackage

// File: rtl/int_pri_queue_if.sv
// Request/response bundle between interrupt sources, CPU and the queue.
interface int_pri_queue_if #(
    parameter int unsigned WID      = 28,
    parameter int unsigned PRI_BITS = 4,
    parameter int unsigned CNT_W    = 8
);
    localparam int unsigned NLEV = 1 << PRI_BITS;

    logic [PRI_BITS-1:0] cpri;
    logic                wr;
    logic [WID-1:0]      i;
    logic                rd;
    logic [WID-1:0]      o;
    logic                ov;
    logic                pending;
    logic [NLEV-1:0]     full;
    logic                empty;
    logic                underflow;
    logic                drop;
    logic [CNT_W-1:0]    drop_cnt;

    modport master (
        output cpri, wr, i, rd,
        input  o, ov, pending, full, empty, underflow, drop, drop_cnt
    );

    modport slave (
        input  cpri, wr, i, rd,
        output o, ov, pending, full, empty, underflow, drop, drop_cnt
    );
endinterface

// File: rtl/int_level_fifo.sv
// Single-priority-level request FIFO with first-word-fall-through head.
module int_level_fifo
    import int_queue_pkg::*;
#(
    parameter int unsigned WID   = 28,
    parameter int unsigned DEPTH = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           push,
    input  logic           pop,
    input  logic [WID-1:0] din,
    output logic [WID-1:0] head,
    output logic           empty,
    output logic           full
);
    localparam int unsigned AW = log2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WID-1:0] mem [DEPTH];
    logic [AW-1:0]  wptr;
    logic [AW-1:0]  rptr;
    logic [CW-1:0]  count;

    // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) wptr <= wptr + AW'(1);
            if (pop)  rptr <= rptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= din;
    end

    assign head  = mem[rptr];
    assign empty = (count == '0);
    assign full  = (count == CW'(DEPTH));

endmodule

// File: rtl/int_pri_queue.sv
// Priority-sorted interrupt queue: one FIFO per level, strict-priority pop above cpri.
module int_pri_queue
    import int_queue_pkg::*;
#(
    parameter int unsigned WID      = DEF_WID,
    parameter int unsigned PRI_BITS = DEF_PRI_BITS,
    parameter int unsigned DEPTH    = 8,
    parameter int unsigned CNT_W    = 8
) (
    input  logic              clk,
    input  logic              rst,
    int_pri_queue_if.slave    bus
);
    localparam int unsigned NLEV = 1 << PRI_BITS;

    logic [NLEV-1:0]     lev_empty;
    logic [NLEV-1:0]     lev_full;
    logic [NLEV-1:0]     elig;
    logic [NLEV-1:0]     push;
    logic [NLEV-1:0]     pop;
    logic [WID-1:0]      lev_head [NLEV];
    logic [PRI_BITS-1:0] wlev;
    logic [PRI_BITS-1:0] sel;
    logic                pending_c;
    logic                rd_ok_c;
    logic                drop_c;

    logic [WID-1:0]      o_q;
    logic                ov_q;
    logic                underflow_q;
    logic                drop_q;
    logic [CNT_W-1:0]    drop_cnt_q;

    // Eligibility, select and per-level push/pop; full check sees same-cycle pop.
    always_comb begin
        elig    = '0;
        push    = '0;
        pop     = '0;
        wlev    = pri_of(bus.i);
        for (int unsigned l = 0; l < NLEV; l++) begin
            elig[l] = !lev_empty[l] && (PRI_BITS'(l) > bus.cpri);
        end
        sel       = hi_bit(elig);
        pending_c = |elig;
        rd_ok_c   = bus.rd && pending_c;
        if (rd_ok_c) pop[sel] = 1'b1;
        if (bus.wr && (!lev_full[wlev] || pop[wlev])) push[wlev] = 1'b1;
        drop_c = bus.wr && lev_full[wlev] && !pop[wlev];
    end

    for (genvar g = 0; g < NLEV; g++) begin : g_lev
        int_level_fifo #(
            .WID   (WID),
            .DEPTH (DEPTH)
        ) u_fifo (
            .clk   (clk),
            .rst   (rst),
            .push  (push[g]),
            .pop   (pop[g]),
            .din   (bus.i),
            .head  (lev_head[g]),
            .empty (lev_empty[g]),
            .full  (lev_full[g])
        );
    end

    // Read data register, status pulses and saturating drop counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            o_q         <= '0;
            ov_q        <= 1'b0;
            underflow_q <= 1'b0;
            drop_q      <= 1'b0;
            drop_cnt_q  <= '0;
        end else begin
            ov_q        <= rd_ok_c;
            underflow_q <= bus.rd && !pending_c;
            drop_q      <= drop_c;
            if (rd_ok_c) o_q <= lev_head[sel];
            if (drop_c && (drop_cnt_q != '1)) drop_cnt_q <= drop_cnt_q + CNT_W'(1);
        end
    end

    assign bus.o         = o_q;
    assign bus.ov        = ov_q;
    assign bus.underflow = underflow_q;
    assign bus.drop      = drop_q;
    assign bus.drop_cnt  = drop_cnt_q;
    assign bus.pending   = pending_c;
    assign bus.full      = lev_full;
    assign bus.empty     = &lev_empty;

endmodule

// File: tb/tb_int_pri_queue.sv
// Directed bench for int_pri_queue with hand-computed expectations.
module tb_int_pri_queue;

    localparam int unsigned WID      = 28;
    localparam int unsigned PRI_BITS = 4;
    localparam int unsigned DEPTH    = 8;
    localparam int unsigned CNT_W    = 8;

    logic clk;
    logic rst;
    int   n_run;
    int   n_fail;

    int_pri_queue_if #(.WID(WID), .PRI_BITS(PRI_BITS), .CNT_W(CNT_W)) bus ();

    int_pri_queue #(
        .WID      (WID),
        .PRI_BITS (PRI_BITS),
        .DEPTH    (DEPTH),
        .CNT_W    (CNT_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [WID-1:0] w(input int unsigned pri, input int unsigned pay);
        logic [WID-1:0] r;
        r = {PRI_BITS'(pri), (WID-PRI_BITS)'(pay)};
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_run++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        n_run  = 0;
        n_fail = 0;
        rst      = 1'b1;
        bus.cpri = '0;
        bus.wr   = 1'b0;
        bus.i    = '0;
        bus.rd   = 1'b0;
        tick();
        rst = 1'b0;

        // reset state
        chk("rst_ov",       32'(bus.ov), 32'd0);
        chk("rst_empty",    32'(bus.empty), 32'd1);
        chk("rst_pending",  32'(bus.pending), 32'd0);
        chk("rst_full",     32'(bus.full), 32'd0);
        chk("rst_drop_cnt", 32'(bus.drop_cnt), 32'd0);
        chk("rst_o",        32'(bus.o), 32'd0);

        // priority order
        bus.cpri = 4'd0;
        bus.wr = 1'b1; bus.i = w(3, 'h111); tick();
        bus.i = w(7, 'h222); tick();
        bus.i = w(3, 'h333); tick();
        bus.wr = 1'b0;
        chk("po_pending", 32'(bus.pending), 32'd1);
        chk("po_empty",   32'(bus.empty), 32'd0);
        bus.rd = 1'b1; tick();
        chk("po_ov0", 32'(bus.ov), 32'd1);
        chk("po_o0",  32'(bus.o), 32'(w(7, 'h222)));
        tick();
        chk("po_ov1", 32'(bus.ov), 32'd1);
        chk("po_o1",  32'(bus.o), 32'(w(3, 'h111)));
        tick();
        chk("po_ov2", 32'(bus.ov), 32'd1);
        chk("po_o2",  32'(bus.o), 32'(w(3, 'h333)));
        bus.rd = 1'b0; tick();
        chk("po_idle_ov", 32'(bus.ov), 32'd0);
        chk("po_hold_o",  32'(bus.o), 32'(w(3, 'h333)));
        chk("po_empty2",  32'(bus.empty), 32'd1);

        // masking
        bus.cpri = 4'd5;
        bus.wr = 1'b1; bus.i = w(4, 'hAAA); tick();
        bus.wr = 1'b0;
        chk("mk_pending", 32'(bus.pending), 32'd0);
        bus.rd = 1'b1; tick();
        bus.rd = 1'b0;
        chk("mk_underflow", 32'(bus.underflow), 32'd1);
        chk("mk_ov",        32'(bus.ov), 32'd0);
        chk("mk_empty",     32'(bus.empty), 32'd0);
        chk("mk_o_hold",    32'(bus.o), 32'(w(3, 'h333)));
        bus.cpri = 4'd4; #1;
        chk("mk_eq_cpri", 32'(bus.pending), 32'd0);
        bus.cpri = 4'd3; #1;
        chk("mk_unmask", 32'(bus.pending), 32'd1);
        bus.rd = 1'b1; tick();
        bus.rd = 1'b0;
        chk("mk_ov2", 32'(bus.ov), 32'd1);
        chk("mk_o2",  32'(bus.o), 32'(w(4, 'hAAA)));
        chk("mk_uf2", 32'(bus.underflow), 32'd0);

        // full and drop on level 2
        bus.cpri = 4'd0;
        bus.wr = 1'b1;
        for (int k = 0; k < 8; k++) begin
            bus.i = w(2, 'h200 + k); tick();
        end
        chk("fd_full8", 32'(bus.full), 32'h0004);
        chk("fd_nodrop", 32'(bus.drop), 32'd0);
        bus.i = w(2, 'h2FF); tick();
        bus.wr = 1'b0;
        chk("fd_drop",     32'(bus.drop), 32'd1);
        chk("fd_drop_cnt", 32'(bus.drop_cnt), 32'd1);
        chk("fd_full9",    32'(bus.full), 32'h0004);
        bus.rd = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tick();
            chk("fd_pop_ov", 32'(bus.ov), 32'd1);
            chk("fd_pop_o",  32'(bus.o), 32'(w(2, 'h200 + k)));
        end
        bus.rd = 1'b0; tick();
        chk("fd_empty", 32'(bus.empty), 32'd1);
        chk("fd_full0", 32'(bus.full), 32'd0);

        // same-cycle push/pop on a full level
        bus.wr = 1'b1;
        for (int k = 0; k < 8; k++) begin
            bus.i = w(6, 'h600 + k); tick();
        end
        chk("sc_full", 32'(bus.full), 32'h0040);
        bus.i = w(6, 'hBEE); bus.rd = 1'b1; tick();
        bus.wr = 1'b0;
        chk("sc_nodrop", 32'(bus.drop), 32'd0);
        chk("sc_cnt",    32'(bus.drop_cnt), 32'd1);
        chk("sc_o0",     32'(bus.o), 32'(w(6, 'h600)));
        chk("sc_full2",  32'(bus.full), 32'h0040);
        for (int k = 1; k < 8; k++) begin
            tick();
            chk("sc_pop_o", 32'(bus.o), 32'(w(6, 'h600 + k)));
        end
        tick();
        chk("sc_last_ov", 32'(bus.ov), 32'd1);
        chk("sc_last_o",  32'(bus.o), 32'(w(6, 'hBEE)));
        bus.rd = 1'b0; tick();
        chk("sc_empty", 32'(bus.empty), 32'd1);

        // level 0 is never eligible
        bus.wr = 1'b1; bus.i = w(0, 'h005); tick();
        bus.wr = 1'b0;
        chk("l0_pending", 32'(bus.pending), 32'd0);
        chk("l0_empty",   32'(bus.empty), 32'd0);
        bus.rd = 1'b1; tick();
        bus.rd = 1'b0;
        chk("l0_underflow", 32'(bus.underflow), 32'd1);
        chk("l0_ov",        32'(bus.ov), 32'd0);

        // drop counter saturation on level 1 (starts at 1, 260 more drops)
        bus.wr = 1'b1;
        for (int k = 0; k < 8 + 260; k++) begin
            bus.i = w(1, 'h100 + k); tick();
        end
        bus.wr = 1'b0;
        chk("sat_cnt",  32'(bus.drop_cnt), 32'd255);
        chk("sat_full", 32'(bus.full), 32'h0002);

        // reset mid-stream with a read in flight
        bus.wr = 1'b1;
        bus.i = w(9, 'h901); tick();
        bus.i = w(9, 'h902); tick();
        bus.i = w(9, 'h903); tick();
        bus.wr = 1'b0;
        bus.rd = 1'b1; rst = 1'b1; tick();
        rst = 1'b0; bus.rd = 1'b0;
        chk("rm_ov",       32'(bus.ov), 32'd0);
        chk("rm_empty",    32'(bus.empty), 32'd1);
        chk("rm_pending",  32'(bus.pending), 32'd0);
        chk("rm_full",     32'(bus.full), 32'd0);
        chk("rm_drop_cnt", 32'(bus.drop_cnt), 32'd0);
        chk("rm_o",        32'(bus.o), 32'd0);
        bus.rd = 1'b1; tick();
        bus.rd = 1'b0;
        chk("rm_gone_uf", 32'(bus.underflow), 32'd1);
        chk("rm_gone_ov", 32'(bus.ov), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
